// File: rtl/tc_delay_queue.sv
// Elastic delay queue: a circular buffer whose head may only be read once it
// has been stored for at least DELAY clock edges; writer and reader both handshake.
module tc_delay_queue #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int DELAY     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [BIT_WIDTH-1:0]         in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [BIT_WIDTH-1:0]         out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int AW = $clog2(DELAY + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BIT_WIDTH-1:0] r_data [DEPTH];
    logic [AW-1:0]        r_age  [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic w_push;
    logic w_pop;
    logic w_head_aged;
    logic w_not_empty;

    assign w_not_empty = (r_count != '0);
    assign w_head_aged = (r_age[r_rd_ptr] == AW'(DELAY));

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = w_not_empty && w_head_aged;
    assign out_data  = w_not_empty ? r_data[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // A non-zero age marks an occupied slot: push writes 1 and pop clears it,
    // so ageing needs no separate occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_age[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (PW'(i) == r_wr_ptr)) begin
                    r_data[i] <= in_data;
                    r_age[i]  <= AW'(1);
                end else if (w_pop && (PW'(i) == r_rd_ptr)) begin
                    r_age[i] <= '0;
                end else if ((r_age[i] != '0) && (r_age[i] < AW'(DELAY))) begin
                    r_age[i] <= r_age[i] + AW'(1);
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/tc_delay_queue.md
Name: tc_delay_queue

Overview:
Elastic counterpart to the fixed delay line. The producer side pushes words with a valid/ready handshake. The consumer side drains each word only after it has aged a programmable minimum number of cycles. Used where delayed data must survive back-pressure from the reader instead of being overwritten every clock.

Parameters:
BIT_WIDTH, 8, data word width (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
DELAY, 2, minimum age in clock edges before an entry may be read; 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low; clears all state while 0
in_valid  input  1  producer offers in_data
in_data  input  BIT_WIDTH  producer word
in_ready  output  1  queue can accept a word this cycle
out_valid  output  1  head entry present and aged >= DELAY
out_data  output  BIT_WIDTH  head entry data
out_ready  input  1  consumer takes the head word this cycle
count  output  clog2(DEPTH+1)  number of stored entries, including not-yet-aged ones

Behaviour:
- Reset (rst=0, asynchronous): storage and ages zeroed; wr_ptr=rd_ptr=0; count=0.
- Outputs during reset: in_ready=1, out_valid=0, out_data=0. Reset mid-operation discards every entry, aged or not.
- Storage: circular buffer of DEPTH entries. Each entry holds data plus an age counter of width clog2(DELAY+1).
- Push: occurs at an edge when in_valid && in_ready. The entry at wr_ptr gets data=in_data and age=1; wr_ptr increments modulo DEPTH.
- Ageing: every edge, each occupied entry's age increments, saturating at DELAY. A newly pushed entry is not incremented on its write edge.
- in_ready = (count < DEPTH). It depends only on registered state. There is no same-cycle pop-to-push bypass when full.
- out_valid = (count != 0) && (age[rd_ptr] == DELAY). out_data = data[rd_ptr] when count != 0, else 0.
- Pop: occurs at an edge when out_valid && out_ready. rd_ptr increments modulo DEPTH; the vacated entry's age is cleared.
- Latency: a word pushed at edge k raises out_valid right after edge k+DELAY-1.
  - With DELAY=2 and out_ready held at 1, this matches the plain two-register delay line: a word sampled at edge k appears after edge k+1.
  - With DELAY=1, the word is readable the cycle after it is pushed.
- FIFO order is strict. A younger entry is never output before the head, even if the head is stalled.
- Stability: while out_valid && !out_ready, out_valid and out_data hold.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count==DEPTH a pop is accepted but the push is refused (in_ready=0). in_ready rises the following cycle.
- count: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows.
- Ignored inputs: in_valid while in_ready=0 and out_ready while out_valid=0 are ignored with no state change.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_data=0, count=0. Assert rst=0 mid-stream with 3 entries stored -> same values immediately, without a clock edge.
- Stream: DELAY=2, out_ready=1, push 0x11,0x22,0x33 on edges 1..3 -> out_valid/out_data show 0x11,0x22,0x33 after edges 2,3,4; count peaks at 2.
- Fill: DEPTH=4, out_ready=0, push 0xA0..0xA4 -> first four accepted, count=4, in_ready=0, 0xA4 refused. Release out_ready -> 0xA0..0xA3 drain in order; in_ready=1 after the first pop.
- Full with simultaneous push and pop -> pop of head succeeds, push refused that cycle, count=3 next cycle. Push retried next cycle is accepted and count returns to 4.
- Head stall: out_ready=0 for 5 cycles with out_valid=1 -> out_data held constant. Entries behind the head have saturated ages, so they pop on consecutive edges once ready returns.
- Wrap and DELAY=1: push/pop 10 words through DEPTH=4 -> in-order output with no loss; each word is visible the cycle after its push.
